// File: rtl/pocket_joypad_events_if.sv
// Button-word interface between the gamepad synchroniser side (master)
// and the event generator (slave).
interface pocket_joypad_events_if;
  logic [15:0] iJOY;
  logic [15:0] oHELD;
  logic [15:0] oPRESS;
  logic [15:0] oRELEASE;
  logic [15:0] oREPEAT;
  logic        oANY_PRESS;

  modport master (
    output iJOY,
    input  oHELD, oPRESS, oRELEASE, oREPEAT, oANY_PRESS
  );

  modport slave (
    input  iJOY,
    output oHELD, oPRESS, oRELEASE, oREPEAT, oANY_PRESS
  );
endinterface

// File: rtl/pocket_joypad_events.sv
// Pocket joypad event stage: debounces the synchronised button word and
// produces held levels, press/release pulses and typematic repeat pulses.
// All timing runs off one prescaled tick shared by every bit.
module pocket_joypad_events #(
  parameter int          TICK_DIV    = 48000,
  parameter int          DB_TICKS    = 5,
  parameter int          REP_DELAY   = 400,
  parameter int          REP_RATE    = 80,
  parameter logic [15:0] REPEAT_MASK = 16'h000F
) (
  input  logic                   iCLK,
  input  logic                   iRST_N,
  pocket_joypad_events_if.slave  bus
);

  localparam int DIV_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DB_W    = (DB_TICKS > 0) ? $clog2(DB_TICKS + 1) : 1;
  localparam int REP_MAX = (REP_DELAY > REP_RATE) ? REP_DELAY : REP_RATE;
  localparam int REP_W   = $clog2(REP_MAX + 1);

  typedef enum logic [1:0] {
    ST_OFF,
    ST_DELAY,
    ST_RPT
  } rep_state_e;

  logic [DIV_W-1:0] div_q;
  logic             tick;

  logic [DB_W-1:0]  db_q [16];
  logic [DB_W-1:0]  db_d [16];
  logic [15:0]      held_q, held_d;
  logic [15:0]      press_q, release_q;
  logic             any_press_q;
  logic [15:0]      rise, fall;

  rep_state_e       st_q [16];
  rep_state_e       st_d [16];
  logic [REP_W-1:0] rc_q [16];
  logic [REP_W-1:0] rc_d [16];
  logic [15:0]      rep_q, rep_d;

  // Prescaler: free-running 0..TICK_DIV-1, tick on the terminal count.
  always_ff @(posedge iCLK) begin
    // NOTE: sequential state uses <= so every register updates from pre-edge values.
    if (!iRST_N)   div_q <= '0;
    else if (tick) div_q <= '0;
    else           div_q <= div_q + 1'b1;
  end

  assign tick = (div_q == DIV_W'(TICK_DIV - 1));

  // Debounce: accept a new level after DB_TICKS consecutive disagreeing ticks.
  always_comb begin
    for (int i = 0; i < 16; i++) begin
      // NOTE: every combinational output gets a default first so no latch is inferred.
      db_d[i]   = db_q[i];
      held_d[i] = held_q[i];
      if (DB_TICKS == 0) begin
        held_d[i] = bus.iJOY[i];
        db_d[i]   = '0;
      end else if (bus.iJOY[i] == held_q[i]) begin
        db_d[i] = '0;
      end else if (tick) begin
        if (db_q[i] == DB_W'(DB_TICKS - 1)) begin
          held_d[i] = ~held_q[i];
          db_d[i]   = '0;
        end else begin
          db_d[i] = db_q[i] + 1'b1;
        end
      end
    end
  end

  assign rise = held_d & ~held_q;
  assign fall = ~held_d & held_q;

  // Held levels and edge pulses, registered together so they change on one edge.
  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      // NOTE: the per-bit counter arrays are plain flops and are cleared on reset like any other state.
      for (int i = 0; i < 16; i++) db_q[i] <= '0;
      held_q      <= '0;
      press_q     <= '0;
      release_q   <= '0;
      any_press_q <= 1'b0;
    end else begin
      for (int i = 0; i < 16; i++) db_q[i] <= db_d[i];
      held_q      <= held_d;
      press_q     <= rise;
      release_q   <= fall;
      any_press_q <= |rise;
    end
  end

  // Repeat FSM state register, including the registered repeat pulse.
  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      for (int i = 0; i < 16; i++) begin
        st_q[i] <= ST_OFF;
        rc_q[i] <= '0;
      end
      rep_q <= '0;
    end else begin
      for (int i = 0; i < 16; i++) begin
        st_q[i] <= st_d[i];
        rc_q[i] <= rc_d[i];
      end
      rep_q <= rep_d;
    end
  end

  // Repeat FSM next state: arm on press, count ticks, drop out on release.
  always_comb begin
    for (int i = 0; i < 16; i++) begin
      st_d[i] = st_q[i];
      rc_d[i] = rc_q[i];
      if (!REPEAT_MASK[i] || fall[i]) begin
        st_d[i] = ST_OFF;
        rc_d[i] = '0;
      end else begin
        case (st_q[i])
          ST_OFF: begin
            if (rise[i]) begin
              st_d[i] = ST_DELAY;
              rc_d[i] = '0;
            end
          end
          ST_DELAY: begin
            if (tick) begin
              if (rc_q[i] == REP_W'(REP_DELAY - 1)) begin
                st_d[i] = ST_RPT;
                rc_d[i] = '0;
              end else begin
                rc_d[i] = rc_q[i] + 1'b1;
              end
            end
          end
          ST_RPT: begin
            if (tick) begin
              if (rc_q[i] == REP_W'(REP_RATE - 1)) rc_d[i] = '0;
              else                                  rc_d[i] = rc_q[i] + 1'b1;
            end
          end
          default: begin
            st_d[i] = ST_OFF;
            rc_d[i] = '0;
          end
        endcase
      end
    end
  end

  // Repeat FSM output: pulse on the expiring tick unless a release lands on it.
  always_comb begin
    rep_d = '0;
    for (int i = 0; i < 16; i++) begin
      rep_d[i] = REPEAT_MASK[i] && !fall[i] && tick &&
                 (((st_q[i] == ST_DELAY) && (rc_q[i] == REP_W'(REP_DELAY - 1))) ||
                  ((st_q[i] == ST_RPT)   && (rc_q[i] == REP_W'(REP_RATE - 1))));
    end
  end

  assign bus.oHELD      = held_q;
  assign bus.oPRESS     = press_q;
  assign bus.oRELEASE   = release_q;
  assign bus.oREPEAT    = rep_q;
  assign bus.oANY_PRESS = any_press_q;

endmodule
